// File: rtl/data_cache_pkg.sv
// Shared definitions for the data cache: FSM state encoding, default
// geometry and address-field width helpers.
package dcache_pkg;

   localparam int DEF_NUM_LINES      = 64;
   localparam int DEF_WORDS_PER_LINE = 4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WRITEBACK,
      S_REFILL,
      S_UPDATE
   } dcache_state_t;

   // Word-offset field width.
   function automatic int off_w(input int words_per_line);
      return $clog2(words_per_line);
   endfunction

   // Line-index field width.
   function automatic int idx_w(input int num_lines);
      return $clog2(num_lines);
   endfunction

   // Tag width: whatever remains above byte, offset and index bits.
   function automatic int tag_w(input int num_lines, input int words_per_line);
      return 32 - 2 - $clog2(words_per_line) - $clog2(num_lines);
   endfunction

endpackage

// File: rtl/data_cache_if.sv
// Core-side and memory-side bus bundles of the data cache.
// master drives the request, slave answers it.

interface dcache_core_if;
   logic        core_req;
   logic        core_we;
   logic [3:0]  core_be;
   logic [31:0] core_addr;
   logic [31:0] core_wdata;
   logic [31:0] core_rdata;
   logic        core_stall;

   modport master (output core_req, core_we, core_be, core_addr, core_wdata,
                   input  core_rdata, core_stall);
   modport slave  (input  core_req, core_we, core_be, core_addr, core_wdata,
                   output core_rdata, core_stall);
endinterface

interface dcache_mem_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                   input  mem_rdata, mem_ack);
   modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                   output mem_rdata, mem_ack);
endinterface

// File: rtl/data_cache_line_store.sv
// Per-line storage: valid/dirty flops (reset), tag and data arrays (no reset).
// One combinational read port and one byte-enabled word write port, both
// addressed by the same line index; fill_i installs a freshly refilled line.
module dcache_line_store
   import dcache_pkg::*;
#(
   parameter int NUM_LINES      = DEF_NUM_LINES,
   parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
   localparam int OW = off_w(WORDS_PER_LINE),
   localparam int IW = idx_w(NUM_LINES),
   localparam int TW = tag_w(NUM_LINES, WORDS_PER_LINE)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [IW-1:0]                    idx_i,
   output logic                             valid_o,
   output logic                             dirty_o,
   output logic [TW-1:0]                    tag_o,
   output logic [WORDS_PER_LINE-1:0][31:0]  line_o,
   input  logic                             wr_en_i,
   input  logic [OW-1:0]                    wr_off_i,
   input  logic [3:0]                       wr_be_i,
   input  logic [31:0]                      wr_data_i,
   input  logic                             wr_dirty_i,
   input  logic                             fill_i,
   input  logic [TW-1:0]                    fill_tag_i
);

   logic [NUM_LINES-1:0]              valid_q;
   logic [NUM_LINES-1:0]              dirty_q;
   logic [TW-1:0]                     tag_q  [NUM_LINES];
   logic [WORDS_PER_LINE-1:0][31:0]   data_q [NUM_LINES];

   assign valid_o = valid_q[idx_i];
   assign dirty_o = dirty_q[idx_i];
   assign tag_o   = tag_q[idx_i];
   assign line_o  = data_q[idx_i];

   // Line status: fill makes the line valid and clean, a store marks it dirty.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (fill_i) begin
         valid_q[idx_i] <= 1'b1;
         dirty_q[idx_i] <= 1'b0;
      end else if (wr_en_i && wr_dirty_i) begin
         dirty_q[idx_i] <= 1'b1;
      end
   end

   // Tag and data arrays; contents are don't-care after reset.
   always_ff @(posedge clk) begin
      if (fill_i)
         tag_q[idx_i] <= fill_tag_i;
      if (wr_en_i) begin
         for (int b = 0; b < 4; b++)
            if (wr_be_i[b])
               data_q[idx_i][wr_off_i][8*b +: 8] <= wr_data_i[8*b +: 8];
      end
   end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back / write-allocate data cache.
// Hits finish in the request cycle; misses stall the core while the FSM
// writes back a dirty victim and refills the line one word per mem_ack.
// Optional build macro: DCACHE_STATS_EN enables the hit/miss counters.
module data_cache
   import dcache_pkg::*;
#(
   parameter int NUM_LINES      = DEF_NUM_LINES,
   parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
   input  logic         clk,
   input  logic         reset,
   dcache_core_if.slave core,
   dcache_mem_if.master mem,
   output logic [31:0]  hit_count,
   output logic [31:0]  miss_count
);

   localparam int OW = off_w(WORDS_PER_LINE);
   localparam int IW = idx_w(NUM_LINES);
   localparam int TW = tag_w(NUM_LINES, WORDS_PER_LINE);
   localparam logic [OW-1:0] LAST_BEAT = OW'(WORDS_PER_LINE - 1);

   dcache_state_t state_q, state_d;
   logic [OW-1:0] beat_q, beat_d;

   // The core holds its request stable during a miss, so the request
   // address also indexes the victim/refill line throughout.
   logic [OW-1:0] req_off;
   logic [IW-1:0] req_idx;
   logic [TW-1:0] req_tag;
   logic          unused_addr_lsb;

   assign req_off         = core.core_addr[2 +: OW];
   assign req_idx         = core.core_addr[2+OW +: IW];
   assign req_tag         = core.core_addr[31 -: TW];
   assign unused_addr_lsb = ^core.core_addr[1:0];

   logic                            line_valid, line_dirty;
   logic [TW-1:0]                   line_tag;
   logic [WORDS_PER_LINE-1:0][31:0] line_data;
   logic                            wr_en, wr_dirty, fill;
   logic [OW-1:0]                   wr_off;
   logic [3:0]                      wr_be;
   logic [31:0]                     wr_data;

   dcache_line_store #(
      .NUM_LINES      (NUM_LINES),
      .WORDS_PER_LINE (WORDS_PER_LINE)
   ) u_store (
      .clk        (clk),
      .reset      (reset),
      .idx_i      (req_idx),
      .valid_o    (line_valid),
      .dirty_o    (line_dirty),
      .tag_o      (line_tag),
      .line_o     (line_data),
      .wr_en_i    (wr_en),
      .wr_off_i   (wr_off),
      .wr_be_i    (wr_be),
      .wr_data_i  (wr_data),
      .wr_dirty_i (wr_dirty),
      .fill_i     (fill),
      .fill_tag_i (req_tag)
   );

   logic hit, req_hit, req_miss, last_beat;

   assign hit       = line_valid && (line_tag == req_tag);
   assign req_hit   = (state_q == S_IDLE) && core.core_req && hit;
   assign req_miss  = (state_q == S_IDLE) && core.core_req && !hit;
   assign last_beat = (beat_q == LAST_BEAT);

   assign core.core_stall = (state_q != S_IDLE) || req_miss;
   assign core.core_rdata = (req_hit && !core.core_we) ? line_data[req_off] : '0;

   // Memory side is a pure decode of registered state, so it drops as soon
   // as reset forces the FSM back to IDLE.
   assign mem.mem_req   = (state_q == S_WRITEBACK) || (state_q == S_REFILL);
   assign mem.mem_we    = (state_q == S_WRITEBACK);
   assign mem.mem_addr  = (state_q == S_WRITEBACK) ? {line_tag, req_idx, beat_q, 2'b00} :
                          (state_q == S_REFILL)    ? {req_tag,  req_idx, beat_q, 2'b00} : '0;
   assign mem.mem_wdata = (state_q == S_WRITEBACK) ? line_data[beat_q] : '0;

   // FSM state and beat counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
      end
   end

   // Next-state, beat counting and line-store write control.
   always_comb begin
      state_d  = state_q;
      beat_d   = beat_q;
      wr_en    = 1'b0;
      wr_dirty = 1'b0;
      wr_off   = req_off;
      wr_be    = core.core_be;
      wr_data  = core.core_wdata;
      fill     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_hit && core.core_we) begin
               wr_en    = 1'b1;
               wr_dirty = 1'b1;
            end else if (req_miss) begin
               beat_d  = '0;
               state_d = (line_valid && line_dirty) ? S_WRITEBACK : S_REFILL;
            end
         end
         S_WRITEBACK: begin
            if (mem.mem_ack) begin
               beat_d = beat_q + 1'b1;
               if (last_beat) begin
                  beat_d  = '0;
                  state_d = S_REFILL;
               end
            end
         end
         S_REFILL: begin
            if (mem.mem_ack) begin
               wr_en   = 1'b1;
               wr_off  = beat_q;
               wr_be   = 4'hF;
               wr_data = mem.mem_rdata;
               beat_d  = beat_q + 1'b1;
               if (last_beat)
                  state_d = S_UPDATE;
            end
         end
         S_UPDATE: begin
            fill    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

`ifdef DCACHE_STATS_EN
   logic [31:0] hit_cnt_q, miss_cnt_q;

   // Statistics: the post-refill replay is an ordinary hit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         if (req_hit)  hit_cnt_q  <= hit_cnt_q + 32'd1;
         if (req_miss) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
   end

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
`else
   assign hit_count  = '0;
   assign miss_count = '0;
`endif

endmodule

// File: tb/tb_data_cache.sv
// Directed + randomized bench for data_cache against a line-level model.
module tb_data_cache;
   import dcache_pkg::*;

   localparam int NL  = DEF_NUM_LINES;
   localparam int WPL = DEF_WORDS_PER_LINE;
   localparam int LB  = 4 * WPL;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] hit_count, miss_count;

   dcache_core_if cif();
   dcache_mem_if  mif();

   data_cache #(.NUM_LINES(NL), .WORDS_PER_LINE(WPL)) dut (
      .clk        (clk),
      .reset      (reset),
      .core       (cif),
      .mem        (mif),
      .hit_count  (hit_count),
      .miss_count (miss_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] data;
   } beat_t;

   beat_t       beat_log[$];
   logic [31:0] mem_arr [logic [29:0]];
   logic [31:0] ref_mem [logic [29:0]];
   int          ack_delay  = 1;
   int          stable_err = 0;
   int          n_chk = 0, n_pass = 0;

   // Model state
   bit          m_valid [NL];
   bit          m_dirty [NL];
   int unsigned m_tag   [NL];
   logic [31:0] m_data  [NL][WPL];
   int unsigned exp_hits = 0, exp_miss = 0;

   function automatic logic [31:0] init_word(input logic [29:0] wa);
      return ({2'b00, wa} * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   function automatic logic [31:0] tb_rd(input logic [29:0] wa);
      if (!mem_arr.exists(wa)) mem_arr[wa] = init_word(wa);
      return mem_arr[wa];
   endfunction

   function automatic logic [31:0] ref_rd(input logic [29:0] wa);
      if (!ref_mem.exists(wa)) ref_mem[wa] = init_word(wa);
      return ref_mem[wa];
   endfunction

   function automatic logic [31:0] stat_exp(input int unsigned v);
`ifdef DCACHE_STATS_EN
      return v;
`else
      return (v == 0) ? 32'd0 : 32'd0;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Backing memory: acks each beat after ack_delay cycles, logs every beat.
   initial begin : responder
      int          wait_cnt;
      logic [31:0] beat_addr;
      wait_cnt      = 0;
      beat_addr     = '0;
      mif.mem_ack   = 1'b0;
      mif.mem_rdata = '0;
      forever begin
         @(negedge clk);
         mif.mem_ack   = 1'b0;
         mif.mem_rdata = '0;
         if (mif.mem_req === 1'b1 && !reset) begin
            if (wait_cnt == 0) beat_addr = mif.mem_addr;
            else if (mif.mem_addr !== beat_addr) stable_err++;
            if (wait_cnt >= ack_delay - 1) begin
               wait_cnt    = 0;
               mif.mem_ack = 1'b1;
               if (mif.mem_we) mem_arr[mif.mem_addr[31:2]] = mif.mem_wdata;
               else            mif.mem_rdata = tb_rd(mif.mem_addr[31:2]);
               beat_log.push_back('{mif.mem_addr, mif.mem_we,
                                    mif.mem_we ? mif.mem_wdata : mif.mem_rdata});
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   // One core access, predicted by the model and checked on completion.
   // Entered and left at posedge+1.
   task automatic txn(input logic we, input logic [3:0] be, input logic [31:0] addr,
                      input logic [31:0] wdata, input int delay, input string tag,
                      output logic [31:0] rd, output int stalls);
      int unsigned a, idx, tg, off, exp_stall;
      logic [31:0] exp_rd, va;
      beat_t       exp_b[$];
      a   = addr;
      off = (a / 4) % WPL;
      idx = (a / LB) % NL;
      tg  = a / (LB * NL);
      ack_delay = delay;
      beat_log.delete();
      if (m_valid[idx] && m_tag[idx] == tg) begin
         exp_stall = 0;
      end else begin
         exp_miss++;
         exp_stall = 2 + WPL * delay;
         if (m_valid[idx] && m_dirty[idx]) begin
            exp_stall += WPL * delay;
            for (int k = 0; k < WPL; k++) begin
               va = 32'((m_tag[idx] * NL + idx) * LB + k * 4);
               exp_b.push_back('{va, 1'b1, m_data[idx][k]});
               ref_mem[va[31:2]] = m_data[idx][k];
            end
         end
         for (int k = 0; k < WPL; k++) begin
            va = 32'((a / LB) * LB + k * 4);
            m_data[idx][k] = ref_rd(va[31:2]);
            exp_b.push_back('{va, 1'b0, m_data[idx][k]});
         end
         m_valid[idx] = 1'b1;
         m_dirty[idx] = 1'b0;
         m_tag[idx]   = tg;
      end
      exp_hits++;
      if (we) begin
         for (int b = 0; b < 4; b++)
            if (be[b]) m_data[idx][off][8*b +: 8] = wdata[8*b +: 8];
         m_dirty[idx] = 1'b1;
      end
      exp_rd = m_data[idx][off];

      cif.core_req   = 1'b1;
      cif.core_we    = we;
      cif.core_be    = be;
      cif.core_addr  = addr;
      cif.core_wdata = wdata;
      stalls = 0;
      rd     = '0;
      while (1) begin
         @(negedge clk);
         if (cif.core_stall === 1'b0) begin
            rd = cif.core_rdata;
            break;
         end
         stalls++;
         if (stalls > 300) break;
      end
      @(posedge clk); #1;
      cif.core_req = 1'b0;
      cif.core_we  = 1'b0;

      chk({tag, " stall"}, 32'(stalls), exp_stall);
      if (!we) chk({tag, " rdata"}, rd, exp_rd);
      chk({tag, " beats"}, 32'(beat_log.size()), 32'(exp_b.size()));
      for (int i = 0; i < exp_b.size() && i < beat_log.size(); i++) begin
         chk($sformatf("%s beat%0d addr", tag, i), beat_log[i].addr, exp_b[i].addr);
         chk($sformatf("%s beat%0d we",   tag, i), 32'(beat_log[i].we), 32'(exp_b[i].we));
         chk($sformatf("%s beat%0d data", tag, i), beat_log[i].data, exp_b[i].data);
      end
      chk({tag, " hit_count"},  hit_count,  stat_exp(exp_hits));
      chk({tag, " miss_count"}, miss_count, stat_exp(exp_miss));
   endtask

   initial begin : main
      logic [31:0] rd, addr;
      int          st, found;

      cif.core_req   = 1'b0;
      cif.core_we    = 1'b0;
      cif.core_be    = 4'h0;
      cif.core_addr  = '0;
      cif.core_wdata = '0;
      for (int i = 0; i < NL; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
         m_tag[i]   = 0;
      end

      // Reset values
      @(negedge clk); @(negedge clk);
      chk("rst core_stall", 32'(cif.core_stall), 0);
      chk("rst core_rdata", cif.core_rdata, 0);
      chk("rst mem_req",    32'(mif.mem_req), 0);
      chk("rst mem_we",     32'(mif.mem_we), 0);
      chk("rst mem_addr",   mif.mem_addr, 0);
      chk("rst mem_wdata",  mif.mem_wdata, 0);
      chk("rst hit_count",  hit_count, 0);
      chk("rst miss_count", miss_count, 0);
      @(posedge clk); #1 reset = 1'b0;
      @(posedge clk); #1;

      // Cold load
      mem_arr[30'h40] = 32'hDEAD_BEEF;
      ref_mem[30'h40] = 32'hDEAD_BEEF;
      txn(1'b0, 4'h0, 32'h0000_0100, '0, 1, "cold", rd, st);
      chk("cold value", rd, 32'hDEAD_BEEF);
      if (beat_log.size() == 4) chk("cold last beat", beat_log[3].addr, 32'h10C);

      // Byte-enabled store hit
      txn(1'b1, 4'hF,    32'h0000_0104, 32'hAABB_CCDD, 1, "st_full", rd, st);
      txn(1'b1, 4'b0011, 32'h0000_0104, 32'h1122_3344, 1, "st_be",   rd, st);
      txn(1'b0, 4'h0,    32'h0000_0104, '0,            1, "ld_be",   rd, st);
      chk("st_be merged", rd, 32'hAABB_3344);

      // Dirty conflict at the same index
      txn(1'b0, 4'h0, 32'h0000_0500, '0, 1, "dirty", rd, st);
      if (beat_log.size() == 8) begin
         chk("dirty wb word1", beat_log[1].data, 32'hAABB_3344);
         chk("dirty wb we",    32'(beat_log[0].we), 1);
         chk("dirty refill0",  beat_log[4].addr, 32'h500);
      end

      // Slow memory: 3 cycles per beat
      stable_err = 0;
      txn(1'b0, 4'h0, 32'h0000_0900, '0, 3, "slow", rd, st);
      chk("slow stall", 32'(st), 14);
      chk("slow addr stable", 32'(stable_err), 0);

      // Reset during the second refill beat
      ack_delay = 2;
      beat_log.delete();
      cif.core_req  = 1'b1;
      cif.core_we   = 1'b0;
      cif.core_addr = 32'h0000_0A00;
      found = 0;
      for (int i = 0; i < 50 && found == 0; i++) begin
         @(negedge clk);
         if (mif.mem_req === 1'b1 && mif.mem_addr === 32'h0000_0A04) found = 1;
      end
      chk("rstmid reached beat2", 32'(found), 1);
      #1 reset = 1'b1;
      #1;
      chk("rstmid mem_req", 32'(mif.mem_req), 0);
      cif.core_req = 1'b0;
      @(posedge clk); #1 reset = 1'b0;
      for (int i = 0; i < NL; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
      end
      exp_hits = 0;
      exp_miss = 0;
      @(posedge clk); #1;
      txn(1'b0, 4'h0, 32'h0000_0A00, '0, 1, "reload", rd, st);

      // Randomized traffic over a few conflicting lines
      stable_err = 0;
      for (int n = 0; n < 80; n++) begin
         addr = 32'((($urandom_range(0, 3) * NL + $urandom_range(0, 3)) * LB)
                    + $urandom_range(0, WPL - 1) * 4 + $urandom_range(0, 3));
         txn(1'($urandom_range(0, 1)), 4'($urandom), addr, $urandom,
             int'($urandom_range(1, 3)), $sformatf("rnd%0d", n), rd, st);
      end
      chk("rnd addr stable", 32'(stable_err), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-back, write-allocate data cache between the single-cycle core's data-memory port and the multi-cycle backing memory. Hits complete in the core's current cycle with no stall. Misses raise `core_stall` while a finite-state machine writes back the dirty victim line and refills the requested line, one word per memory handshake. Instantiated inside the core in place of direct memory access.

## Interface
- `NUM_LINES`, 64: number of lines; power of two, ≥ 2.
- `WORDS_PER_LINE`, 4: 32-bit words per line; power of two, ≥ 2.
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `core_req` input 1: data access request this cycle.
- `core_we` input 1: 1 = store, 0 = load.
- `core_be` input 4: store byte enables; bit i selects byte lane i, bits [8i+7:8i].
- `core_addr` input 32: byte address; bits [1:0] ignored.
- `core_wdata` input 32: store data.
- `core_rdata` output 32: load data; valid when `core_req & ~core_we & ~core_stall`.
- `core_stall` output 1: core must hold its PC and all request inputs stable.
- `mem_req` output 1: memory beat request.
- `mem_we` output 1: 1 = writeback beat, 0 = refill beat.
- `mem_addr` output 32: word-aligned beat address.
- `mem_wdata` output 32: writeback data.
- `mem_rdata` input 32: refill data; valid with `mem_ack`.
- `mem_ack` input 1: beat accepted or completed in this cycle.
- `hit_count` output 32: statistics counter; see Configuration.
- `miss_count` output 32: statistics counter; see Configuration.

## Operation
- Address split:
  - offset = `addr[2+OW-1:2]`, where OW = log2(`WORDS_PER_LINE`).
  - index = next IW bits, where IW = log2(`NUM_LINES`).
  - tag = the remaining upper bits.
  - With defaults: offset = [3:2], index = [9:4], tag = [31:10].
- Per line state: valid bit, dirty bit, tag, and data words. Valid bits live in flops; tags and data may be flops or an inferred array with combinational read.
- States: IDLE, WRITEBACK, REFILL, UPDATE.
- IDLE:
  - Hit = valid & tag match.
  - On `core_req` & hit: a load returns the word combinationally. A store writes the enabled bytes at the clock edge and sets dirty.
  - On `core_req` & miss: `core_stall`=1. Go to WRITEBACK if the victim is valid & dirty, else to REFILL. Beat counter is cleared.
- WRITEBACK:
  - Beat k sends `mem_addr`={victim tag, index, k, 2'b00}, `mem_we`=1, `mem_wdata`=victim word k.
  - On `mem_ack` the counter increments. After the last beat, go to REFILL with the counter cleared.
- REFILL:
  - Beat k sends {request tag, index, k, 2'b00} with `mem_we`=0.
  - On `mem_ack`, `mem_rdata` is written into word k.
  - After the last beat, go to UPDATE.
- UPDATE: set valid=1, dirty=0, tag=request tag; `core_stall`=1; go to IDLE. The held request then hits on the next cycle. A store sets dirty at that point.
- `mem_req`=1 exactly in WRITEBACK and REFILL. `mem_addr`, `mem_we` and `mem_wdata` are stable until `mem_ack`.
- `core_stall` = (state≠IDLE) | (state==IDLE & `core_req` & miss).
- `core_req`=0 in IDLE: no state change, `core_stall`=0.

## Timing
- Reset values:
  - state=IDLE, counter=0, all valid and dirty bits=0.
  - `core_stall`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `core_rdata`=0, both counters=0.
  - Data and tag contents are don't-care.
- Hit: 0 cycles of stall.
- Clean miss: stall cycles = 1 (miss detect) + Σ REFILL beat durations + 1 (UPDATE), then the hit cycle.
- Dirty miss: add the WRITEBACK beats.
- A beat lasts ≥1 cycle; `mem_ack` in the first cycle gives a one-cycle beat. `mem_req` may stay high across consecutive beats while the address advances.
- `mem_ack` outside WRITEBACK/REFILL is ignored.
- Reset asserted mid-miss: state returns to IDLE immediately (asynchronously) and `mem_req` drops in the same cycle. A partially refilled line is not marked valid.
- The beat counter wraps at `WORDS_PER_LINE`; the terminal beat is detected as counter==`WORDS_PER_LINE`-1 & `mem_ack`.

## Configuration
- `DCACHE_STATS_EN` defined:
  - `hit_count` increments on each IDLE cycle with `core_req` & hit. The post-UPDATE replay counts as a hit.
  - `miss_count` increments on each miss detection.
  - Both counters are 32-bit and wrap modulo 2^32.
- `DCACHE_STATS_EN` undefined: no counter logic; both ports are tied to 0.

## Structure
- Shared package `dcache_pkg`:
  - FSM state enum `dcache_state_t`.
  - Default geometry constants.
  - Address-field width functions (OW, IW, tag width).
- One sub-module, `dcache_line_store`: per-line valid/dirty/tag/data storage with a combinational read port and a byte-enabled write port. The FSM, beat counter and stall logic stay in `data_cache`.

## Test plan
- Cold load from 0x0000_0100 with memory word = 0xDEADBEEF and `mem_ack` on every beat:
  - 4 refill beats at 0x100, 0x104, 0x108, 0x10C.
  - `core_rdata`=0xDEADBEEF; `miss_count`=1, then `hit_count`=1.
- Store 0x11223344 with `core_be`=4'b0011 to a cached word holding 0xAABBCCDD: no stall, subsequent load returns 0xAABB3344, line dirty.
- Dirty conflict: load 0x0000_0500 after the dirty line at 0x100 (same index):
  - 4 writeback beats (`mem_we`=1) at 0x100–0x10C with the line's current data.
  - Then 4 refill beats at 0x500–0x50C.
- `mem_ack` delayed 3 cycles per beat on a clean miss: `mem_addr` held stable, total stall = 1 + 4×3 + 1 = 14 cycles.
- `reset` pulsed during the 2nd refill beat: `mem_req`=0 immediately; a reload of the same address performs a full 4-beat refill.
- With `DCACHE_STATS_EN` undefined: the scenarios above all pass and both counters read 0 throughout.
